systolic_os_array: RTL and testbench

Parametrised output-stationary systolic matrix-multiply array: the next generation of the team's ROWS x COLS PE grid. It adds internal input skewing, a load/flush/drain controller, valid/ready handshakes on both sides, and signed/unsigned MAC with an OUTWIDTH accumulator. It computes C[ROWS][COLS] = A[ROWS][K] * B[K][COLS] from K unskewed operand beats, then streams C out one row per beat. It sits between the operand buffers and the result writeback path.

---
 rtl/systolic_os_array.sv | 220 ++++++++++++++++++++++
 tb/tb_systolic_os_array.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_os_array.sv
`default_nettype none
// ============================================================================
// Module      : systolic_os_array
// Description : Output-stationary ROWS x COLS systolic matrix multiplier with
//               internal operand skew, LOAD/FLUSH/DRAIN control and
//               valid/ready handshakes. Optional macro SATURATE_EN clamps
//               accumulators instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_os_array #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int INWIDTH  = 8,
  parameter int OUTWIDTH = 32,
  parameter int KWIDTH   = 16,
  parameter int SIGNED   = 0,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [KWIDTH-1:0]          k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*INWIDTH-1:0]    in_a,
  input  logic [COLS*INWIDTH-1:0]    in_w,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*OUTWIDTH-1:0]   out_data,
  output logic [RW-1:0]              out_row,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Last beat needs ROWS-1 + COLS-1 hops plus its own MAC edge.
  localparam int c_FLUSH_LEN = ROWS + COLS - 1;
  localparam int c_FW        = $clog2(c_FLUSH_LEN + 1);

  state_t              r_state, w_next;
  logic [KWIDTH-1:0]   r_klen, r_beat;
  logic [c_FW-1:0]     r_flush;
  logic [RW-1:0]       r_row;
  logic                r_done;
  logic                w_start, w_in_hs, w_out_hs;
  logic                w_last_beat, w_flush_end, w_last_row;

  logic [INWIDTH-1:0]  w_a   [ROWS][COLS];
  logic [INWIDTH-1:0]  w_w   [ROWS][COLS];
  logic [OUTWIDTH-1:0] w_acc [ROWS][COLS];

  assign w_start     = (r_state == S_IDLE) && start;
  assign w_in_hs     = (r_state == S_LOAD) && in_valid;
  assign w_out_hs    = (r_state == S_DRAIN) && out_ready;
  assign w_last_beat = (r_beat + KWIDTH'(1)) == r_klen;
  assign w_flush_end = r_flush == c_FW'(c_FLUSH_LEN - 1);
  assign w_last_row  = r_row == RW'(ROWS - 1);

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_DRAIN);
  assign busy      = (r_state != S_IDLE);
  assign out_row   = r_row;
  assign done      = r_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (k_len == '0) ? S_DRAIN : S_LOAD;
      S_LOAD:  if (in_valid && w_last_beat) w_next = S_FLUSH;
      S_FLUSH: if (w_flush_end) w_next = S_DRAIN;
      S_DRAIN: if (out_ready && w_last_row) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Beat, flush and row counters plus the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_klen  <= '0;
      r_beat  <= '0;
      r_flush <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_out_hs && w_last_row;
      if (w_start) begin
        r_klen <= k_len;
        r_beat <= '0;
        r_row  <= '0;
      end
      if (w_in_hs) r_beat <= r_beat + KWIDTH'(1);
      if (r_state == S_FLUSH) r_flush <= r_flush + c_FW'(1);
      else                    r_flush <= '0;
      if (w_out_hs) r_row <= w_last_row ? '0 : r_row + RW'(1);
    end
  end

  // West-edge injection and skew: row i delayed i cycles
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [INWIDTH-1:0] w_inj;
    assign w_inj = w_in_hs ? in_a[gi*INWIDTH +: INWIDTH] : '0;
    if (gi == 0) begin : g_nosk
      assign w_a[gi][0] = w_inj;
    end else begin : g_sk
      logic [INWIDTH-1:0] r_sk [gi];
      // A delay line for this row
      always_ff @(posedge clk) begin
        if (rst || w_start) begin
          for (int k = 0; k < gi; k++) r_sk[k] <= '0;
        end else begin
          r_sk[0] <= w_inj;
          for (int k = 1; k < gi; k++) r_sk[k] <= r_sk[k-1];
        end
      end
      assign w_a[gi][0] = r_sk[gi-1];
    end
  end

  // North-edge injection and skew: column j delayed j cycles
  for (genvar gj = 0; gj < COLS; gj++) begin : g_col
    logic [INWIDTH-1:0] w_inj;
    assign w_inj = w_in_hs ? in_w[gj*INWIDTH +: INWIDTH] : '0;
    if (gj == 0) begin : g_nosk
      assign w_w[0][gj] = w_inj;
    end else begin : g_sk
      logic [INWIDTH-1:0] r_sk [gj];
      // B delay line for this column
      always_ff @(posedge clk) begin
        if (rst || w_start) begin
          for (int k = 0; k < gj; k++) r_sk[k] <= '0;
        end else begin
          r_sk[0] <= w_inj;
          for (int k = 1; k < gj; k++) r_sk[k] <= r_sk[k-1];
        end
      end
      assign w_w[0][gj] = r_sk[gj-1];
    end
  end

  // Processing elements
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_pr
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
      logic [OUTWIDTH-1:0] w_prod, w_acc_nxt, r_acc;

      if (gj > 0) begin : g_ae
        logic [INWIDTH-1:0] r_ap;
        // Pass A one PE east
        always_ff @(posedge clk) begin
          if (rst || w_start) r_ap <= '0;
          else                r_ap <= w_a[gi][gj-1];
        end
        assign w_a[gi][gj] = r_ap;
      end

      if (gi > 0) begin : g_ws
        logic [INWIDTH-1:0] r_wp;
        // Pass B one PE south
        always_ff @(posedge clk) begin
          if (rst || w_start) r_wp <= '0;
          else                r_wp <= w_w[gi-1][gj];
        end
        assign w_w[gi][gj] = r_wp;
      end

      if (SIGNED != 0) begin : g_mul_s
        logic signed [2*INWIDTH-1:0] w_ps;
        assign w_ps   = $signed(w_a[gi][gj]) * $signed(w_w[gi][gj]);
        assign w_prod = OUTWIDTH'(w_ps);
      end else begin : g_mul_u
        logic [2*INWIDTH-1:0] w_pu;
        assign w_pu   = w_a[gi][gj] * w_w[gi][gj];
        assign w_prod = OUTWIDTH'(w_pu);
      end

`ifdef SATURATE_EN
      logic [OUTWIDTH:0] w_sum;
      if (SIGNED != 0) begin : g_sat_s
        assign w_sum = {r_acc[OUTWIDTH-1], r_acc} + {w_prod[OUTWIDTH-1], w_prod};
        // Sign disagreement between the two top bits means overflow.
        assign w_acc_nxt = (w_sum[OUTWIDTH] != w_sum[OUTWIDTH-1])
                         ? (w_sum[OUTWIDTH] ? {1'b1, {(OUTWIDTH-1){1'b0}}}
                                            : {1'b0, {(OUTWIDTH-1){1'b1}}})
                         : w_sum[OUTWIDTH-1:0];
      end else begin : g_sat_u
        assign w_sum     = {1'b0, r_acc} + {1'b0, w_prod};
        assign w_acc_nxt = w_sum[OUTWIDTH] ? '1 : w_sum[OUTWIDTH-1:0];
      end
`else
      assign w_acc_nxt = r_acc + w_prod;
`endif

      // Accumulate every cycle; bubbles and flush inject zero operands
      always_ff @(posedge clk) begin
        if (rst || w_start) r_acc <= '0;
        else                r_acc <= w_acc_nxt;
      end
      assign w_acc[gi][gj] = r_acc;
    end
  end

  // Result row is read straight from the selected row of accumulators
  for (genvar gj = 0; gj < COLS; gj++) begin : g_out
    assign out_data[gj*OUTWIDTH +: OUTWIDTH] = w_acc[r_row][gj];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_os_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_os_array
// Description : Directed table-driven bench for systolic_os_array: default,
//               signed and 16-bit-accumulator instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_os_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, out_ready;
  logic [15:0] k_len;
  logic [31:0] in_a, in_w;
  int          sel;
  logic        st_d, st_s, st_o;

  assign st_d = start && (sel == 0);
  assign st_s = start && (sel == 1);
  assign st_o = start && (sel == 2);

  logic         d_rdy, d_ov, d_busy, d_done, s_rdy, s_ov, s_busy, s_done;
  logic         o_rdy, o_ov, o_busy, o_done;
  logic [127:0] d_data, s_data;
  logic [63:0]  o_data;
  logic [1:0]   d_row, s_row, o_row;

  systolic_os_array u_d (
    .clk(clk), .rst(rst), .start(st_d), .k_len(k_len), .in_valid(in_valid),
    .in_ready(d_rdy), .in_a(in_a), .in_w(in_w), .out_valid(d_ov),
    .out_ready(out_ready), .out_data(d_data), .out_row(d_row),
    .busy(d_busy), .done(d_done));

  systolic_os_array #(.SIGNED(1)) u_s (
    .clk(clk), .rst(rst), .start(st_s), .k_len(k_len), .in_valid(in_valid),
    .in_ready(s_rdy), .in_a(in_a), .in_w(in_w), .out_valid(s_ov),
    .out_ready(out_ready), .out_data(s_data), .out_row(s_row),
    .busy(s_busy), .done(s_done));

  systolic_os_array #(.OUTWIDTH(16)) u_o (
    .clk(clk), .rst(rst), .start(st_o), .k_len(k_len), .in_valid(in_valid),
    .in_ready(o_rdy), .in_a(in_a), .in_w(in_w), .out_valid(o_ov),
    .out_ready(out_ready), .out_data(o_data), .out_row(o_row),
    .busy(o_busy), .done(o_done));

  logic        t_rdy, t_ov, t_busy, t_dn;
  logic [1:0]  t_row;
  logic [31:0] t_data [4];

  // Route the selected instance's outputs to common observation signals
  always_comb begin
    t_rdy = d_rdy; t_ov = d_ov; t_busy = d_busy; t_dn = d_done; t_row = d_row;
    for (int j = 0; j < 4; j++) t_data[j] = d_data[j*32 +: 32];
    if (sel == 1) begin
      t_rdy = s_rdy; t_ov = s_ov; t_busy = s_busy; t_dn = s_done; t_row = s_row;
      for (int j = 0; j < 4; j++) t_data[j] = s_data[j*32 +: 32];
    end else if (sel == 2) begin
      t_rdy = o_rdy; t_ov = o_ov; t_busy = o_busy; t_dn = o_done; t_row = o_row;
      for (int j = 0; j < 4; j++) t_data[j] = {16'h0, o_data[j*16 +: 16]};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic [7:0]  ma [4][4];
  logic [7:0]  mb [4][4];
  logic [31:0] got [4][4];

  typedef struct {
    int          dut;
    int          pat;
    int          k;
    bit          bub;
    int          hold_row;
    int          hold_n;
    int          exp_first;
    bit          ident;
    logic [31:0] exp_c;
  } vec_t;

  vec_t tab [6];

  task automatic set_pattern(input int p);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        case (p)
          0: begin ma[i][j] = (i == j) ? 8'd1 : 8'd0; mb[i][j] = 8'(4*i + j); end
          1: begin ma[i][j] = 8'h80; mb[i][j] = 8'h7F; end
          default: begin ma[i][j] = 8'hFF; mb[i][j] = 8'hFF; end
        endcase
      end
  endtask

  task automatic run_job(input vec_t v, input int n);
    int cyc = 0, beat = 0, held = 0, post = 0;
    int first = -1, nhs = 0, last_hs = -1, ndone = 0, nout = 0;
    bit ok;
    logic [31:0] snap [4];
    logic [1:0]  snaprow;
    sel = v.dut;
    set_pattern(v.pat);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) got[i][j] = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b1; k_len = v.k[15:0]; in_valid = 1'b0; out_ready = 1'b1;
    while (cyc < 200 && post < 3) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (t_dn) ndone++;
      if (nout == 4) post++;
      // operand side: garbage on the bus whenever no real beat is offered
      ok = (beat < v.k) && (!v.bub || (cyc % 2 == 1));
      in_valid = ok || (beat >= v.k);
      for (int i = 0; i < 4; i++) begin
        in_a[i*8 +: 8] = ok ? ma[i][beat] : 8'hAA;
        in_w[i*8 +: 8] = ok ? mb[beat][i] : 8'h55;
      end
      if (ok && t_rdy) begin beat++; nhs++; last_hs = cyc; end
      // result side
      out_ready = 1'b1;
      if (t_ov) begin
        if (first < 0) first = cyc;
        if (v.hold_row >= 0 && int'(t_row) == v.hold_row && held < v.hold_n) begin
          if (held == 0) begin
            snaprow = t_row;
            for (int j = 0; j < 4; j++) snap[j] = t_data[j];
          end else begin
            check($sformatf("v%0d_hold_row", n), 32'(t_row), 32'(snaprow));
            for (int j = 0; j < 4; j++)
              check($sformatf("v%0d_hold_data%0d", n, j), t_data[j], snap[j]);
          end
          out_ready = 1'b0;
          held++;
        end else begin
          check($sformatf("v%0d_row_order", n), 32'(t_row), nout);
          for (int j = 0; j < 4; j++) got[t_row][j] = t_data[j];
          nout++;
        end
      end
    end
    in_valid = 1'b0;
    if (cyc >= 200) begin
      total++; bad++;
      $display("FAIL v%0d_timeout: got %0d cycles want under 200", n, cyc);
    end
    check($sformatf("v%0d_first_valid", n), first, v.exp_first);
    check($sformatf("v%0d_handshakes", n), nhs, v.k);
    check($sformatf("v%0d_rows_out", n), nout, 4);
    check($sformatf("v%0d_done_pulses", n), ndone, 1);
    check($sformatf("v%0d_busy_after", n), 32'(t_busy), 0);
    if (v.k > 0) check($sformatf("v%0d_flush_len", n), first - last_hs, 8);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        check($sformatf("v%0d_C%0d%0d", n, i, j), got[i][j],
              v.ident ? 32'(4*i + j) : v.exp_c);
  endtask

  initial begin
    //          dut pat k  bub hrow hn first ident exp_c
    tab[0] = '{0, 0, 4, 1'b0, -1, 0, 12, 1'b1, 32'h0};
    tab[1] = '{1, 1, 4, 1'b0, -1, 0, 12, 1'b0, 32'hFFFF0200};
    tab[2] = '{0, 0, 4, 1'b1, -1, 0, 15, 1'b1, 32'h0};
    tab[3] = '{0, 0, 0, 1'b0, -1, 0, 1,  1'b0, 32'h0};
    tab[4] = '{0, 0, 4, 1'b0, 1,  5, 12, 1'b1, 32'h0};
`ifdef SATURATE_EN
    tab[5] = '{2, 2, 2, 1'b0, -1, 0, 10, 1'b0, 32'h0000FFFF};
`else
    tab[5] = '{2, 2, 2, 1'b0, -1, 0, 10, 1'b0, 32'h0000FC02};
`endif

    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_w = '0; sel = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(t_busy), 0);
    check("reset_in_ready", 32'(t_rdy), 0);
    check("reset_out_valid", 32'(t_ov), 0);
    check("reset_done", 32'(t_dn), 0);
    check("reset_out_row", 32'(t_row), 0);
    check("reset_out_data0", t_data[0], 0);

    for (int n = 0; n < 6; n++) run_job(tab[n], n);

    // Reset in the middle of LOAD after two accepted beats
    sel = 0;
    set_pattern(0);
    @(negedge clk);
    start = 1'b1; k_len = 16'd4;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        in_a[i*8 +: 8] = ma[i][b];
        in_w[i*8 +: 8] = mb[b][i];
      end
    end
    @(negedge clk);
    check("midload_in_ready", 32'(t_rdy), 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(t_busy), 0);
    check("abort_in_ready", 32'(t_rdy), 0);
    check("abort_out_valid", 32'(t_ov), 0);
    begin
      int dn = 0;
      for (int c = 0; c < 5; c++) begin
        if (t_dn) dn++;
        @(negedge clk);
      end
      check("abort_no_done", dn, 0);
    end
    run_job(tab[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
